// File: rtl/stream_to_xillybus_rd_pkg.sv
// -----------------------------------------------------------------------------
// stream_to_xillybus_rd_pkg
// Shared definitions for the pixel-stream to Xillybus read-port adapter:
//   - xb_state_e : frame FSM states (idle, streaming, draining, end-of-file)
//   - PAD_W      : number of zero bits prepended to each pixel (32 - 24)
//   - cnt_width(): width of a counter that can hold 0..frame_pixels
// -----------------------------------------------------------------------------
package stream_to_xillybus_rd_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_EOF    = 2'd3
  } xb_state_e;

  localparam int DEF_IN_W = 24;
  localparam int PAD_W    = 8;

  // 2^(clog2(n)+1) >= 2n > n, so the counter can always represent n itself.
  function automatic int cnt_width(input int frame_pixels);
    return $clog2(frame_pixels) + 1;
  endfunction

endpackage

// File: rtl/stream_to_xillybus_rd_if.sv
// -----------------------------------------------------------------------------
// stream_to_xillybus_rd_if
// Bundles the upstream ready/valid pixel stream and the Xillybus read port.
//   io_in_valid/io_in_ready/io_in_bits : upstream pixel handshake
//   user_r_open/user_r_rden            : host side controls
//   user_r_empty/user_r_data/user_r_eof: host side status and data
// Modports: slave = the adapter, master = the surrounding environment.
// -----------------------------------------------------------------------------
interface stream_to_xillybus_rd_if #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 32
);
  logic             io_in_valid;
  logic             io_in_ready;
  logic [IN_W-1:0]  io_in_bits;
  logic             user_r_open;
  logic             user_r_rden;
  logic             user_r_empty;
  logic [OUT_W-1:0] user_r_data;
  logic             user_r_eof;

  modport slave (
    input  io_in_valid, io_in_bits, user_r_open, user_r_rden,
    output io_in_ready, user_r_empty, user_r_data, user_r_eof
  );

  modport master (
    output io_in_valid, io_in_bits, user_r_open, user_r_rden,
    input  io_in_ready, user_r_empty, user_r_data, user_r_eof
  );
endinterface

// File: rtl/stream_to_xillybus_rd_xb_sync_fifo.sv
// -----------------------------------------------------------------------------
// xb_sync_fifo
// DEPTH x W single-clock buffer with a registered output word.
//   push/din : write din when not full
//   pop      : load dout from the oldest entry when not empty (1-cycle latency)
//   flush    : clear pointers, count and dout; overrides push/pop
//   count/full/empty : occupancy, all derived from the registered count
// -----------------------------------------------------------------------------
module xb_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic [W-1:0]  dout
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Storage is not reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_to_xillybus_rd.sv
// -----------------------------------------------------------------------------
// stream_to_xillybus_rd
// Egress adapter from a 24-bit ready/valid pixel stream to the Xillybus read
// port. Buffers pixels locally, zero-pads them to OUT_W bits, counts pixels in
// the frame and raises eof once a full frame has been delivered to the host.
//   clk, reset_n : bus clock, asynchronous active-low reset
//   bus          : pixel stream + Xillybus read port (slave modport)
//   frame_done   : one-cycle pulse when eof is first raised
//   rd_err       : sticky flag, host strobed rden while empty
// A new frame starts only after the host closes and reopens the device file.
// -----------------------------------------------------------------------------
module stream_to_xillybus_rd
  import stream_to_xillybus_rd_pkg::*;
#(
  parameter int IN_W         = DEF_IN_W,
  parameter int OUT_W        = IN_W + PAD_W,
  parameter int DEPTH        = 16,
  parameter int FRAME_PIXELS = 307200,
  parameter int CNT_W        = cnt_width(FRAME_PIXELS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  stream_to_xillybus_rd_if.slave   bus,
  output logic                     frame_done,
  output logic                     rd_err
);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int PAD_N = OUT_W - IN_W;

  xb_state_e        state;
  xb_state_e        state_nxt;
  logic [CNT_W-1:0] pix_cnt;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             push;
  logic             flush;
  logic             last_pixel;
  logic [OUT_W-1:0] din;

  // Closing the file resets the whole frame context, whatever the state.
  assign flush      = !bus.user_r_open;
  // Decoded from registered state and count only, so a same-cycle pop never
  // frees room for a push.
  assign bus.io_in_ready  = (state == S_STREAM) && !full;
  assign push             = bus.io_in_valid && bus.io_in_ready;
  assign last_pixel       = push && (pix_cnt == CNT_W'(FRAME_PIXELS - 1));
  assign din              = {{PAD_N{1'b0}}, bus.io_in_bits};
  assign bus.user_r_empty = empty;
  assign bus.user_r_eof   = (state == S_EOF);

  xb_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (OUT_W),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (bus.user_r_rden),
    .flush   (flush),
    .din     (din),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .dout    (bus.user_r_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!bus.user_r_open) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state_nxt = S_STREAM;
        S_STREAM: if (last_pixel) state_nxt = S_DRAIN;
        S_DRAIN:  if (count == '0) state_nxt = S_EOF;
        S_EOF:    state_nxt = S_EOF;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Pushes only happen in STREAM, so the counter freezes once DRAIN is entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt    <= '0;
      frame_done <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      if (flush)     pix_cnt <= '0;
      else if (push) pix_cnt <= pix_cnt + 1'b1;
      frame_done <= (state == S_DRAIN) && (state_nxt == S_EOF);
      if (bus.user_r_rden && empty) rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_to_xillybus_rd.sv
// -----------------------------------------------------------------------------
// tb_stream_to_xillybus_rd
// Drives two adapters (DEPTH=4; FRAME_PIXELS=4 and 8) with identical inputs
// and compares both against a queue-based frame model after every clock.
// -----------------------------------------------------------------------------
module tb_stream_to_xillybus_rd;

  localparam int DEPTH    = 4;
  localparam int P_IDLE   = 0;
  localparam int P_STREAM = 1;
  localparam int P_DRAIN  = 2;
  localparam int P_EOF    = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        open_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        rden_i = 1'b0;
  logic [23:0] bits_i = '0;
  logic        done_a, done_b, err_a, err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_to_xillybus_rd_if #(.IN_W(24), .OUT_W(32)) ia ();
  stream_to_xillybus_rd_if #(.IN_W(24), .OUT_W(32)) ib ();

  assign ia.io_in_valid = valid_i;
  assign ia.io_in_bits  = bits_i;
  assign ia.user_r_open = open_i;
  assign ia.user_r_rden = rden_i;
  assign ib.io_in_valid = valid_i;
  assign ib.io_in_bits  = bits_i;
  assign ib.user_r_open = open_i;
  assign ib.user_r_rden = rden_i;

  stream_to_xillybus_rd #(.IN_W(24), .OUT_W(32), .DEPTH(DEPTH), .FRAME_PIXELS(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ia.slave), .frame_done(done_a), .rd_err(err_a)
  );

  stream_to_xillybus_rd #(.IN_W(24), .OUT_W(32), .DEPTH(DEPTH), .FRAME_PIXELS(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ib.slave), .frame_done(done_b), .rd_err(err_b)
  );

  // Reference model: one entry per instance (0 = frame of 4, 1 = frame of 8).
  int          m_frame [2] = '{4, 8};
  int          m_phase [2];
  int          m_pix   [2];
  logic [31:0] m_data  [2];
  logic        m_err   [2];
  logic        m_done  [2];
  logic [31:0] m_q     [2][$];

  function automatic logic m_ready(int k);
    return (m_phase[k] == P_STREAM) && (m_q[k].size() < DEPTH);
  endfunction

  function automatic logic m_empty(int k);
    return m_q[k].size() == 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = P_IDLE;
      m_pix[k]   = 0;
      m_data[k]  = '0;
      m_err[k]   = 1'b0;
      m_done[k]  = 1'b0;
      m_q[k].delete();
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int   held;
      logic was_empty;
      logic rdy;
      logic do_push;
      held      = m_q[k].size();
      was_empty = (held == 0);
      rdy       = m_ready(k);
      if (rden_i && was_empty) m_err[k] = 1'b1;
      m_done[k] = 1'b0;
      if (!open_i) begin
        m_phase[k] = P_IDLE;
        m_pix[k]   = 0;
        m_data[k]  = '0;
        m_q[k].delete();
      end else begin
        do_push = valid_i && rdy;
        if (rden_i && !was_empty) m_data[k] = m_q[k].pop_front();
        if (do_push) m_q[k].push_back({8'h00, bits_i});
        case (m_phase[k])
          P_IDLE:   m_phase[k] = P_STREAM;
          P_STREAM: if (do_push) begin
                      m_pix[k]++;
                      if (m_pix[k] == m_frame[k]) m_phase[k] = P_DRAIN;
                    end
          P_DRAIN:  if (held == 0) begin
                      m_phase[k] = P_EOF;
                      m_done[k]  = 1'b1;
                    end
          default:  m_phase[k] = m_phase[k];
        endcase
      end
    end
  endtask

  task automatic check_word(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check_bit ("a.ready", ia.io_in_ready,  m_ready(0));
    check_bit ("a.empty", ia.user_r_empty, m_empty(0));
    check_word("a.data",  ia.user_r_data,  m_data[0]);
    check_bit ("a.eof",   ia.user_r_eof,   m_phase[0] == P_EOF);
    check_bit ("a.done",  done_a,          m_done[0]);
    check_bit ("a.err",   err_a,           m_err[0]);
    check_bit ("b.ready", ib.io_in_ready,  m_ready(1));
    check_bit ("b.empty", ib.user_r_empty, m_empty(1));
    check_word("b.data",  ib.user_r_data,  m_data[1]);
    check_bit ("b.eof",   ib.user_r_eof,   m_phase[1] == P_EOF);
    check_bit ("b.done",  done_b,          m_done[1]);
    check_bit ("b.err",   err_b,           m_err[1]);
  endtask

  task automatic apply_stimulus(logic o, logic v, logic [23:0] b, logic r);
    open_i  = o;
    valid_i = v;
    bits_i  = b;
    rden_i  = r;
    model_step();
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    // Asynchronous reset at time 2, held across two clock edges.
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_output();
    #14 reset_n = 1'b1;

    // Read while empty right after open sets rd_err; ready follows open.
    apply_stimulus(1'b1, 1'b0, 24'h0, 1'b1);
    check_bit ("open.ready", ia.io_in_ready, 1'b1);
    check_bit ("open.rd_err", err_a, 1'b1);
    check_word("open.data", ia.user_r_data, 32'h0);

    // Single pixel round trip.
    apply_stimulus(1'b1, 1'b1, 24'h123456, 1'b0);
    check_bit("push.empty", ia.user_r_empty, 1'b0);
    apply_stimulus(1'b1, 1'b0, 24'h0, 1'b1);
    check_word("pop.data", ia.user_r_data, 32'h00123456);
    check_bit ("pop.empty", ia.user_r_empty, 1'b1);

    // Close keeps rd_err.
    apply_stimulus(1'b0, 1'b0, 24'h0, 1'b0);
    check_bit("close.rd_err", err_a, 1'b1);

    // Fill to full with no reads, then drain; frame of 4 reaches eof.
    apply_stimulus(1'b1, 1'b0, 24'h0, 1'b0);
    for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, 1'b1, 24'(i), 1'b0);
    check_bit("full.ready", ia.io_in_ready, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(1'b1, 1'b0, 24'h0, 1'b1);
      check_word("drain.data", ia.user_r_data, 32'(i));
    end
    check_bit("drain.noeof", ia.user_r_eof, 1'b0);
    apply_stimulus(1'b1, 1'b0, 24'h0, 1'b0);
    check_bit("eof.eof", ia.user_r_eof, 1'b1);
    check_bit("eof.done", done_a, 1'b1);
    apply_stimulus(1'b1, 1'b0, 24'h0, 1'b0);
    check_bit("eof.done_pulse", done_a, 1'b0);

    // Two pushes then close flushes everything.
    apply_stimulus(1'b0, 1'b0, 24'h0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 24'h0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 24'($urandom), 1'b0);
    apply_stimulus(1'b1, 1'b1, 24'($urandom), 1'b0);
    apply_stimulus(1'b0, 1'b0, 24'h0, 1'b0);
    check_bit ("flush.ready", ia.io_in_ready, 1'b0);
    check_bit ("flush.empty", ia.user_r_empty, 1'b1);
    check_word("flush.data", ia.user_r_data, 32'h0);

    // Continuous push and pop: frame of 8 wraps the pointers twice.
    apply_stimulus(1'b1, 1'b0, 24'h0, 1'b0);
    for (int i = 0; i < 12; i++) apply_stimulus(1'b1, 1'b1, 24'($urandom), 1'b1);
    check_bit("stream.eof_b", ib.user_r_eof, 1'b1);

    // Randomised traffic with occasional close/reopen.
    for (int i = 0; i < 800; i++) begin
      apply_stimulus(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
                     24'($urandom), ($urandom_range(0, 2) == 0));
    end

    // Asynchronous reset in the middle of DRAIN.
    apply_stimulus(1'b0, 1'b0, 24'h0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 24'h0, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 24'($urandom), 1'b0);
    #3 reset_n = 1'b0;
    model_reset();
    #1 check_output();
    check_bit("areset.empty", ia.user_r_empty, 1'b1);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 24'($urandom), 1'b0);
    check_bit("idle.ready", ia.io_in_ready, 1'b0);
    apply_stimulus(1'b1, 1'b1, 24'($urandom), 1'b0);
    check_bit("reopen.ready", ia.io_in_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
